quad_sum_accum: RTL and testbench
=================================

Name: quad_sum_accum

Overview:
- Downstream consumer of the 4-operand adder's 10-bit sum.
- Accumulates a fixed window of 2**N_LOG2 valid sums and emits the window total plus the truncated mean.
- Valid/ready handshake on both sides.
- Keeps accumulating the next window while the previous result waits to be accepted.

Parameters:
- IN_W, 10, width of incoming sum (adder output width).
- N_LOG2, 4, log2 of window length; window = 2**N_LOG2 samples; legal range 1..8.
- ACC_W, IN_W+N_LOG2, accumulator/total width; derived, never overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous discard of the partial window.
- in_valid  in  1  in_sum is valid.
- in_ready  out  1  block accepts in_sum this cycle.
- in_sum  in  IN_W  unsigned sum from adder stage.
- out_valid  out  1  out_total/out_avg valid.
- out_ready  in  1  downstream accepts result.
- out_total  out  ACC_W  unsigned window total.
- out_avg  out  IN_W  out_total >> N_LOG2 (truncating).
- win_cnt  out  N_LOG2  samples accepted in current partial window.

Behaviour:
- Asynchronous reset (rst_n=0): acc=0, win_cnt=0, out_valid=0, out_total=0, out_avg=0. in_ready=0 while reset is asserted.
- Reset mid-window or mid-hold discards everything; no result is emitted.
- Accept event = in_valid && in_ready.
- Window-complete = accept while win_cnt == 2**N_LOG2-1.
- in_ready = !clr && !(win_cnt == 2**N_LOG2-1 && out_valid && !out_ready).
  - Stalls only when the completing sample has nowhere to go.
  - Combinational on out_ready: intended pass-through.
- Accept, not window-complete: acc <= acc + in_sum; win_cnt <= win_cnt + 1.
- Window-complete:
  - out_total <= acc + in_sum; out_avg <= (acc + in_sum) >> N_LOG2.
  - out_valid <= 1; acc <= 0; win_cnt <= 0.
- Latency: result visible one cycle after the completing sample's accept edge.
- Output hold: out_valid, out_total and out_avg are stable until out_valid && out_ready.
  - On that handshake with no simultaneous window-complete: out_valid <= 0.
  - Handshake and window-complete in the same cycle: new result loads and out_valid stays 1, giving back-to-back windows at full throughput.
- No overflow: ACC_W is sized so 2**N_LOG2 * (2**IN_W - 1) fits exactly. There is no wrap and no saturation logic.
- clr=1:
  - acc <= 0; win_cnt <= 0; in_ready=0, so any concurrent in_valid sample is not accepted.
  - Does not touch out_valid or the held result; the output handshake proceeds normally.
- Window wrap: win_cnt counts 0..2**N_LOG2-1 and returns to 0 only via window-complete or clr.
- in_sum must be held stable while in_valid=1 and in_ready=0. The block never drops an offered sample.
- Control is a counter plus output-register flag. No further FSM states are required: ACCUM is implicit, and HOLD equals out_valid.

Decomposition:
- Package quad_sum_pkg:
  - IN_W constant = 10, shared with the adder stage.
  - Function acc_width(in_w, n_log2).
  - Typedef sum_t = logic [IN_W-1:0].
- One natural sub-module: sum_out_reg. It is the valid/ready output holding register (load, hold, pop, simultaneous pop+load), reusable by other datapath stages.
- Accumulator and counter stay in the top.

Test Plan (N_LOG2=2, window 4):
- Reset then in_sum 1020 x4, out_ready=1 -> one cycle after 4th accept: out_valid=1, out_total=4080, out_avg=1020, win_cnt=0.
- Sums 1,2,3,5 -> out_total=11, out_avg=2 (truncation).
- out_ready=0 after window 1 (10,10,10,10 -> total 40); feed 7,7,7 accepted, 4th sample 9 stalls with in_ready=0 and the result stays 40. Raise out_ready -> 40 popped; 9 accepted the same cycle -> next out_total=30, out_avg=7.
- Continuous in_valid and out_ready=1 over 3 windows of value 100 -> out_total=400 every 4 cycles, no in_ready drop, no bubble.
- Feed 2 samples of 50, pulse clr with in_valid=1, sum=999 -> 999 not accepted, win_cnt=0. Next 4 samples of 1 -> out_total=4.
- Assert rst_n=0 after 3 samples and while a result is held -> out_valid=0, out_total=0, win_cnt=0 immediately (asynchronous). After release, 4 samples of 2 -> out_total=8.

Source files
------------

// File: rtl/quad_sum_pkg.sv
// Types and constants shared between the 4-operand adder and its downstream consumers.
package quad_sum_pkg;

    localparam int IN_W = 10;

    typedef logic [IN_W-1:0] sum_t;

    // A window of 2**n_log2 samples of in_w bits needs exactly n_log2 extra bits.
    function automatic int acc_width(input int in_w, input int n_log2);
        return in_w + n_log2;
    endfunction

endpackage

// File: rtl/sum_out_reg.sv
// Valid/ready result holding register: load, hold until taken, pop, or pop+load together.
module sum_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;

    // A load wins over a pop, so a result taken in the same cycle is replaced without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;

endmodule

// File: rtl/quad_sum_accum.sv
// Sums fixed windows of 2**N_LOG2 adder results and emits the window total and truncated mean.
module quad_sum_accum #(
    parameter  int IN_W   = quad_sum_pkg::IN_W,
    parameter  int N_LOG2 = 4,
    localparam int ACC_W  = quad_sum_pkg::acc_width(IN_W, N_LOG2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [IN_W-1:0]   out_avg,
    output logic [N_LOG2-1:0] win_cnt
);

    import quad_sum_pkg::*;

    logic [ACC_W-1:0]      acc_reg;
    logic [N_LOG2-1:0]     win_cnt_reg;
    logic [ACC_W-1:0]      sum_next;
    logic [IN_W-1:0]       avg_next;
    logic                  win_last;
    logic                  accept;
    logic                  win_done;
    logic [ACC_W+IN_W-1:0] res_data;

    assign win_last = &win_cnt_reg;
    assign sum_next = acc_reg + ACC_W'(in_sum);
    assign avg_next = IN_W'(sum_next >> N_LOG2);

    // Only the completing sample can be blocked, and only when the held result is not leaving now.
    assign in_ready = rst_n && !clr && !(win_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign win_done = accept && win_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            win_cnt_reg <= '0;
        end else if (clr) begin
            acc_reg     <= '0;
            win_cnt_reg <= '0;
        end else if (accept) begin
            if (win_last) begin
                acc_reg     <= '0;
                win_cnt_reg <= '0;
            end else begin
                acc_reg     <= sum_next;
                win_cnt_reg <= win_cnt_reg + N_LOG2'(1);
            end
        end
    end

    sum_out_reg #(
        .DATA_W (ACC_W + IN_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (win_done),
        .load_data ({sum_next, avg_next}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (res_data)
    );

    assign out_total = res_data[ACC_W+IN_W-1:IN_W];
    assign out_avg   = res_data[IN_W-1:0];
    assign win_cnt   = win_cnt_reg;

endmodule

// File: tb/tb_quad_sum_accum.sv
// Directed and randomized checks of quad_sum_accum (window of 4) against a sample-queue model.
module tb_quad_sum_accum;

    localparam int N_LOG2 = 2;
    localparam int WIN    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_total;
    logic [9:0]  out_avg;
    logic [1:0]  win_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: samples of the open window, and the result the consumer should see.
    int q_win[$];
    bit m_valid;
    int m_total;
    bit last_acc;

    quad_sum_accum #(
        .N_LOG2 (N_LOG2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .out_avg   (out_avg),
        .win_cnt   (win_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_total"}, 32'(out_total), m_total);
        chk({tag, ".out_avg"},   32'(out_avg),   m_total / WIN);
        chk({tag, ".win_cnt"},   32'(win_cnt),   q_win.size());
    endtask

    // Called at a falling edge: drive, check in_ready, advance the model, and check after the next rising edge.
    task automatic cycle(input string tag, input logic v, input int s, input logic ordy, input logic c);
        logic rdy;
        bit   done;
        bit   pop;
        int   sum;
        in_valid  = v;
        in_sum    = s[9:0];
        out_ready = ordy;
        clr       = c;
        #1;
        rdy = !c && !(q_win.size() == WIN - 1 && m_valid && !ordy);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        pop      = m_valid && ordy;
        done     = 1'b0;
        last_acc = v && rdy;
        if (c) begin
            q_win.delete();
        end else if (last_acc) begin
            q_win.push_back(s);
            if (q_win.size() == WIN) begin
                sum = 0;
                foreach (q_win[k]) sum += q_win[k];
                m_total = sum;
                m_valid = 1'b1;
                done    = 1'b1;
                q_win.delete();
            end
        end
        if (pop && !done) m_valid = 1'b0;
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input logic ordy);
        cycle("idle", 1'b0, 0, ordy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic v;
        int   s;
        logic ordy;
        logic c;

        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
        q_win.delete(); m_valid = 1'b0; m_total = 0; last_acc = 1'b0;
        #12;
        chk("rst.in_ready", 32'(in_ready), 0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Full-scale window: no overflow.
        for (int i = 0; i < 4; i++) cycle("max", 1'b1, 1020, 1'b1, 1'b0);
        chk("max.total", 32'(out_total), 4080);
        chk("max.avg",   32'(out_avg),   1020);
        chk("max.valid", 32'(out_valid), 1);
        chk("max.cnt",   32'(win_cnt),   0);

        // Truncating mean.
        cycle("trunc", 1'b1, 1, 1'b1, 1'b0);
        cycle("trunc", 1'b1, 2, 1'b1, 1'b0);
        cycle("trunc", 1'b1, 3, 1'b1, 1'b0);
        cycle("trunc", 1'b1, 5, 1'b1, 1'b0);
        chk("trunc.total", 32'(out_total), 11);
        chk("trunc.avg",   32'(out_avg),   2);

        // Held result stalls only the completing sample.
        for (int i = 0; i < 4; i++) cycle("hold", 1'b1, 10, 1'b1, 1'b0);
        chk("hold.total40", 32'(out_total), 40);
        for (int i = 0; i < 3; i++) cycle("hold7", 1'b1, 7, 1'b0, 1'b0);
        chk("hold.cnt3", 32'(win_cnt), 3);
        for (int i = 0; i < 2; i++) begin
            cycle("stall", 1'b1, 9, 1'b0, 1'b0);
            chk("stall.accepted", 32'(last_acc), 0);
            chk("stall.total", 32'(out_total), 40);
        end
        cycle("release", 1'b1, 9, 1'b1, 1'b0);
        chk("release.accepted", 32'(last_acc), 1);
        chk("release.total", 32'(out_total), 30);
        chk("release.avg",   32'(out_avg),   7);
        chk("release.valid", 32'(out_valid), 1);
        idle(1'b1);

        // Back-to-back windows at full throughput.
        for (int i = 0; i < 12; i++) begin
            cycle("b2b", 1'b1, 100, 1'b1, 1'b0);
            chk("b2b.accepted", 32'(last_acc), 1);
            if (i % 4 == 3) begin
                chk("b2b.valid", 32'(out_valid), 1);
                chk("b2b.total", 32'(out_total), 400);
            end
        end
        idle(1'b1);

        // Clear discards the partial window and blocks the concurrent sample.
        cycle("clr", 1'b1, 50, 1'b1, 1'b0);
        cycle("clr", 1'b1, 50, 1'b1, 1'b0);
        cycle("clr", 1'b1, 999, 1'b1, 1'b1);
        chk("clr.accepted", 32'(last_acc), 0);
        chk("clr.cnt", 32'(win_cnt), 0);
        for (int i = 0; i < 4; i++) cycle("post_clr", 1'b1, 1, 1'b1, 1'b0);
        chk("post_clr.total", 32'(out_total), 4);

        // Asynchronous reset while a result is held and a window is partly filled.
        for (int i = 0; i < 4; i++) cycle("pre_rst", 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 5, 1'b0, 1'b0);
        in_valid = 1'b0; clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q_win.delete(); m_valid = 1'b0; m_total = 0;
        chk("arst.in_ready", 32'(in_ready), 0);
        check_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 2, 1'b1, 1'b0);
        chk("post_rst.total", 32'(out_total), 8);
        idle(1'b1);

        // Randomized traffic; an offered but unaccepted sample is held unchanged.
        v = 1'b0; s = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(v && !last_acc)) begin
                v = ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(0, 1023));
                c = ($urandom_range(0, 19) == 0);
            end else begin
                c = 1'b0;
            end
            ordy = ($urandom_range(0, 2) != 0);
            cycle("rand", v, s, ordy, c);
            if (c) v = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
